// File: rtl/arith_rs_rr.sv
// Reservation station for the arithmetic pipes. Entries are inserted from the issue arbiter and snoop the CDB for
// missing operands. Ready entries dispatch round-robin to an external EU, and results return to the CDB in lowest-index order.
module arith_rs_rr #(
  parameter  int RS_DEPTH       = 8,
  parameter  int EU_CTL_LEN     = 4,
  parameter  int EXCEPT_LEN     = 2,
  parameter  int XLEN           = 64,
  parameter  int ROB_IDX_LEN    = 6,
  parameter  int ROB_EXCEPT_LEN = 5,
  localparam int IDX_W          = $clog2(RS_DEPTH),
  localparam int OCC_W          = IDX_W + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      arbiter_valid_i,
  output logic                      arbiter_ready_o,
  input  logic [EU_CTL_LEN-1:0]     eu_ctl_i,
  input  logic                      rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0]    rs1_idx_i,
  input  logic [XLEN-1:0]           rs1_value_i,
  input  logic                      rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0]    rs2_idx_i,
  input  logic [XLEN-1:0]           rs2_value_i,
  input  logic [ROB_IDX_LEN-1:0]    dest_idx_i,
  output logic                      eu_valid_o,
  input  logic                      eu_ready_i,
  output logic [EU_CTL_LEN-1:0]     eu_ctl_o,
  output logic [XLEN-1:0]           eu_rs1_o,
  output logic [XLEN-1:0]           eu_rs2_o,
  output logic [IDX_W-1:0]          eu_entry_idx_o,
  input  logic                      eu_valid_i,
  output logic                      eu_ready_o,
  input  logic [IDX_W-1:0]          eu_entry_idx_i,
  input  logic [XLEN-1:0]           eu_result_i,
  input  logic                      eu_except_raised_i,
  input  logic [EXCEPT_LEN-1:0]     eu_except_code_i,
  input  logic                      cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0]    cdb_idx_i,
  input  logic [XLEN-1:0]           cdb_data_i,
  input  logic                      cdb_except_raised_i,
  output logic                      cdb_valid_o,
  input  logic                      cdb_ready_i,
  output logic [ROB_IDX_LEN-1:0]    cdb_idx_o,
  output logic [XLEN-1:0]           cdb_data_o,
  output logic                      cdb_except_raised_o,
  output logic [ROB_EXCEPT_LEN-1:0] cdb_except_o,
  output logic [OCC_W-1:0]          occupancy_o
);

  typedef enum logic [2:0] {S_EMPTY, S_WAIT_OPS, S_READY, S_ISSUED, S_DONE} state_e;

  typedef struct packed {
    logic [EU_CTL_LEN-1:0]  ctl;
    logic                   rs1_ready;
    logic [ROB_IDX_LEN-1:0] rs1_idx;
    logic [XLEN-1:0]        rs1_value;
    logic                   rs2_ready;
    logic [ROB_IDX_LEN-1:0] rs2_idx;
    logic [XLEN-1:0]        rs2_value;
    logic [ROB_IDX_LEN-1:0] dest_idx;
    logic [XLEN-1:0]        result;
    logic                   except_raised;
    logic [EXCEPT_LEN-1:0]  except_code;
  } entry_t;

  state_e           state_q [RS_DEPTH];
  state_e           state_d [RS_DEPTH];
  entry_t           entry_q [RS_DEPTH];
  entry_t           entry_d [RS_DEPTH];
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  logic             free_found, done_found, ready_found;
  logic [IDX_W-1:0] free_idx, wb_idx, pick_idx;
  logic             snoop_ok, ins_rs1_ready, ins_rs2_ready;
  logic [XLEN-1:0]  ins_rs1_value, ins_rs2_value;

  // An operand being inserted can also catch a broadcast of its producer in the same cycle.
  assign snoop_ok      = cdb_valid_i && !cdb_except_raised_i;
  assign ins_rs1_ready = rs1_ready_i || (snoop_ok && (cdb_idx_i == rs1_idx_i));
  assign ins_rs2_ready = rs2_ready_i || (snoop_ok && (cdb_idx_i == rs2_idx_i));
  assign ins_rs1_value = rs1_ready_i ? rs1_value_i : cdb_data_i;
  assign ins_rs2_value = rs2_ready_i ? rs2_value_i : cdb_data_i;

  always_comb begin : scan
    logic [IDX_W-1:0] cand;
    // NOTE: every comb output gets a default before the loop; a missing default path infers a latch.
    free_found  = 1'b0;
    free_idx    = '0;
    done_found  = 1'b0;
    wb_idx      = '0;
    ready_found = 1'b0;
    pick_idx    = rr_q;
    cand        = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!free_found && state_q[i] == S_EMPTY) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!done_found && state_q[i] == S_DONE) begin
        done_found = 1'b1;
        wb_idx     = IDX_W'(i);
      end
      cand = rr_q + IDX_W'(i);
      if (!ready_found && state_q[cand] == S_READY) begin
        ready_found = 1'b1;
        pick_idx    = cand;
      end
    end
  end

  assign arbiter_ready_o     = free_found;
  assign eu_ready_o          = 1'b1;
  assign eu_valid_o          = ready_found && !flush_i;
  assign eu_ctl_o            = entry_q[pick_idx].ctl;
  assign eu_rs1_o            = entry_q[pick_idx].rs1_value;
  assign eu_rs2_o            = entry_q[pick_idx].rs2_value;
  assign eu_entry_idx_o      = pick_idx;
  assign cdb_valid_o         = done_found && !flush_i;
  assign cdb_idx_o           = entry_q[wb_idx].dest_idx;
  assign cdb_data_o          = entry_q[wb_idx].result;
  assign cdb_except_raised_o = entry_q[wb_idx].except_raised;
  assign cdb_except_o        = ROB_EXCEPT_LEN'(entry_q[wb_idx].except_code);
  assign occupancy_o         = occupancy_q;

  always_comb begin : next_state
    state_d = state_q;
    entry_d = entry_q;
    rr_d    = rr_q;

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (state_q[i] == S_WAIT_OPS) begin
        if (!entry_q[i].rs1_ready && snoop_ok && (cdb_idx_i == entry_q[i].rs1_idx)) begin
          entry_d[i].rs1_ready = 1'b1;
          entry_d[i].rs1_value = cdb_data_i;
        end
        if (!entry_q[i].rs2_ready && snoop_ok && (cdb_idx_i == entry_q[i].rs2_idx)) begin
          entry_d[i].rs2_ready = 1'b1;
          entry_d[i].rs2_value = cdb_data_i;
        end
        if (entry_d[i].rs1_ready && entry_d[i].rs2_ready) state_d[i] = S_READY;
      end
    end

    if (eu_valid_o && eu_ready_i) begin
      state_d[pick_idx] = S_ISSUED;
      rr_d              = pick_idx + IDX_W'(1);
    end

    // Results for entries that are not in flight (stale or post-flush) are dropped.
    if (eu_valid_i && !flush_i && state_q[eu_entry_idx_i] == S_ISSUED) begin
      state_d[eu_entry_idx_i]               = S_DONE;
      entry_d[eu_entry_idx_i].result        = eu_result_i;
      entry_d[eu_entry_idx_i].except_raised = eu_except_raised_i;
      entry_d[eu_entry_idx_i].except_code   = eu_except_code_i;
    end

    if (cdb_valid_o && cdb_ready_i) state_d[wb_idx] = S_EMPTY;

    if (arbiter_valid_i && free_found) begin
      entry_d[free_idx].ctl           = eu_ctl_i;
      entry_d[free_idx].rs1_ready     = ins_rs1_ready;
      entry_d[free_idx].rs1_idx       = rs1_idx_i;
      entry_d[free_idx].rs1_value     = ins_rs1_value;
      entry_d[free_idx].rs2_ready     = ins_rs2_ready;
      entry_d[free_idx].rs2_idx       = rs2_idx_i;
      entry_d[free_idx].rs2_value     = ins_rs2_value;
      entry_d[free_idx].dest_idx      = dest_idx_i;
      entry_d[free_idx].result        = '0;
      entry_d[free_idx].except_raised = 1'b0;
      entry_d[free_idx].except_code   = '0;
      state_d[free_idx] = (ins_rs1_ready && ins_rs2_ready) ? S_READY : S_WAIT_OPS;
    end

    if (flush_i) begin
      for (int i = 0; i < RS_DEPTH; i++) state_d[i] = S_EMPTY;
    end

    occupancy_d = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (state_d[i] != S_EMPTY) occupancy_d = occupancy_d + OCC_W'(1);
    end
  end

  // NOTE: state is updated only with non-blocking assignments here; blocking ones would race other flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q        <= '0;
      occupancy_q <= '0;
      // NOTE: the payload array is reset too, so idle eu_*/cdb_* outputs read zero out of reset.
      for (int i = 0; i < RS_DEPTH; i++) begin
        state_q[i] <= S_EMPTY;
        entry_q[i] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      occupancy_q <= occupancy_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule

// File: tb/tb_arith_rs_rr.sv
// Directed bench for arith_rs_rr: insert/snoop, round-robin dispatch with wrap, out-of-order completion,
// CDB hold and priority, full-RS back-pressure, and flush with a late EU result.
module tb_arith_rs_rr;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        arbiter_valid_i;
  logic        arbiter_ready_o;
  logic [3:0]  eu_ctl_i;
  logic        rs1_ready_i, rs2_ready_i;
  logic [5:0]  rs1_idx_i, rs2_idx_i, dest_idx_i;
  logic [63:0] rs1_value_i, rs2_value_i;
  logic        eu_valid_o, eu_ready_i;
  logic [3:0]  eu_ctl_o;
  logic [63:0] eu_rs1_o, eu_rs2_o;
  logic [2:0]  eu_entry_idx_o;
  logic        eu_valid_i, eu_ready_o;
  logic [2:0]  eu_entry_idx_i;
  logic [63:0] eu_result_i;
  logic        eu_except_raised_i;
  logic [1:0]  eu_except_code_i;
  logic        cdb_valid_i;
  logic [5:0]  cdb_idx_i;
  logic [63:0] cdb_data_i;
  logic        cdb_except_raised_i;
  logic        cdb_valid_o, cdb_ready_i;
  logic [5:0]  cdb_idx_o;
  logic [63:0] cdb_data_o;
  logic        cdb_except_raised_o;
  logic [4:0]  cdb_except_o;
  logic [3:0]  occupancy_o;

  int n_checks = 0;
  int n_fail   = 0;

  arith_rs_rr #(
    .RS_DEPTH(8), .EU_CTL_LEN(4), .EXCEPT_LEN(2), .XLEN(64), .ROB_IDX_LEN(6), .ROB_EXCEPT_LEN(5)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .arbiter_valid_i(arbiter_valid_i), .arbiter_ready_o(arbiter_ready_o),
    .eu_ctl_i(eu_ctl_i),
    .rs1_ready_i(rs1_ready_i), .rs1_idx_i(rs1_idx_i), .rs1_value_i(rs1_value_i),
    .rs2_ready_i(rs2_ready_i), .rs2_idx_i(rs2_idx_i), .rs2_value_i(rs2_value_i),
    .dest_idx_i(dest_idx_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o),
    .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_entry_idx_o(eu_entry_idx_o),
    .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_entry_idx_i(eu_entry_idx_i),
    .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i), .eu_except_code_i(eu_except_code_i),
    .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_data_i(cdb_data_i),
    .cdb_except_raised_i(cdb_except_raised_i),
    .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_idx_o(cdb_idx_o),
    .cdb_data_o(cdb_data_o), .cdb_except_raised_o(cdb_except_raised_o), .cdb_except_o(cdb_except_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; arbiter_valid_i = 1'b0; eu_ctl_i = '0;
    rs1_ready_i = 1'b0; rs1_idx_i = '0; rs1_value_i = '0;
    rs2_ready_i = 1'b0; rs2_idx_i = '0; rs2_value_i = '0; dest_idx_i = '0;
    eu_ready_i = 1'b0; eu_valid_i = 1'b0; eu_entry_idx_i = '0; eu_result_i = '0;
    eu_except_raised_i = 1'b0; eu_except_code_i = '0;
    cdb_valid_i = 1'b0; cdb_idx_i = '0; cdb_data_i = '0; cdb_except_raised_i = 1'b0;
    cdb_ready_i = 1'b0;
  endtask

  task automatic put(input logic [3:0] ctl, input logic r1r, input logic [5:0] r1i, input logic [63:0] r1v,
                     input logic r2r, input logic [5:0] r2i, input logic [63:0] r2v, input logic [5:0] dst);
    arbiter_valid_i = 1'b1; eu_ctl_i = ctl;
    rs1_ready_i = r1r; rs1_idx_i = r1i; rs1_value_i = r1v;
    rs2_ready_i = r2r; rs2_idx_i = r2i; rs2_value_i = r2v; dest_idx_i = dst;
  endtask

  task automatic bcast(input logic [5:0] tag, input logic [63:0] data, input logic exc);
    cdb_valid_i = 1'b1; cdb_idx_i = tag; cdb_data_i = data; cdb_except_raised_i = exc;
  endtask

  task automatic complete(input logic [2:0] idx, input logic [63:0] res, input logic exc, input logic [1:0] code);
    eu_valid_i = 1'b1; eu_entry_idx_i = idx; eu_result_i = res;
    eu_except_raised_i = exc; eu_except_code_i = code;
  endtask

  task automatic do_flush();
    idle(); flush_i = 1'b1; tick(); idle(); #1;
    check("flush_occ", 64'(occupancy_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n_i = 1'b0;
    #12;
    check("rst_arb_ready", 64'(arbiter_ready_o), 64'd1);
    check("rst_eu_ready",  64'(eu_ready_o),      64'd1);
    check("rst_eu_valid",  64'(eu_valid_o),      64'd0);
    check("rst_cdb_valid", 64'(cdb_valid_o),     64'd0);
    check("rst_occ",       64'(occupancy_o),     64'd0);
    check("rst_cdb_data",  cdb_data_o,           64'd0);
    rst_n_i = 1'b1;
    tick();

    // Basic ADD: 5 + 7 -> dest 3
    put(4'h1, 1'b1, 6'd0, 64'd5, 1'b1, 6'd0, 64'd7, 6'd3);
    tick(); idle(); #1;
    check("add_eu_valid", 64'(eu_valid_o), 64'd1);
    check("add_eu_idx",   64'(eu_entry_idx_o), 64'd0);
    check("add_eu_rs1",   eu_rs1_o, 64'd5);
    check("add_eu_rs2",   eu_rs2_o, 64'd7);
    check("add_eu_ctl",   64'(eu_ctl_o), 64'd1);
    check("add_occ",      64'(occupancy_o), 64'd1);
    eu_ready_i = 1'b1;
    tick(); idle(); #1;
    check("add_issued_no_valid", 64'(eu_valid_o), 64'd0);
    complete(3'd0, 64'd12, 1'b0, 2'd0);
    tick(); idle(); #1;
    check("add_cdb_valid", 64'(cdb_valid_o), 64'd1);
    check("add_cdb_idx",   64'(cdb_idx_o), 64'd3);
    check("add_cdb_data",  cdb_data_o, 64'd12);
    cdb_ready_i = 1'b1;
    tick(); idle(); #1;
    check("add_wb_cdb_valid", 64'(cdb_valid_o), 64'd0);
    check("add_wb_occ",       64'(occupancy_o), 64'd0);

    // Same-cycle snoop at insertion (rr pointer is 1, scan wraps to entry 0)
    put(4'h2, 1'b0, 6'd9, 64'd0, 1'b1, 6'd0, 64'd3, 6'd4);
    bcast(6'd9, 64'hAA, 1'b0);
    tick(); idle(); #1;
    check("ins_snoop_valid", 64'(eu_valid_o), 64'd1);
    check("ins_snoop_idx",   64'(eu_entry_idx_o), 64'd0);
    check("ins_snoop_rs1",   eu_rs1_o, 64'hAA);
    do_flush();

    // Waiting operand: an exception broadcast is not captured, a clean one is
    put(4'h3, 1'b1, 6'd0, 64'd1, 1'b0, 6'd11, 64'd0, 6'd5);
    tick(); idle(); #1;
    check("wait_no_valid", 64'(eu_valid_o), 64'd0);
    check("wait_occ",      64'(occupancy_o), 64'd1);
    bcast(6'd11, 64'h55, 1'b1);
    tick(); idle(); #1;
    check("wait_exc_ignored", 64'(eu_valid_o), 64'd0);
    bcast(6'd11, 64'h77, 1'b0);
    tick(); idle(); #1;
    check("wait_snoop_valid", 64'(eu_valid_o), 64'd1);
    check("wait_snoop_rs2",   eu_rs2_o, 64'h77);
    do_flush();

    // Fill: entry 0 waits on tag 20, entries 1-3 ready, entries 4-7 wait on tag 21
    for (int k = 0; k < 8; k++) begin
      put(4'(k), (k >= 1 && k <= 3), (k == 0) ? 6'd20 : 6'd21, 64'(100 + k),
          1'b1, 6'd0, 64'(200 + k), 6'(10 + k));
      tick();
    end
    idle(); #1;
    check("full_arb_ready", 64'(arbiter_ready_o), 64'd0);
    check("full_occ",       64'(occupancy_o), 64'd8);
    check("full_eu_idx",    64'(eu_entry_idx_o), 64'd1);
    tick();
    check("hold_eu_idx", 64'(eu_entry_idx_o), 64'd1);
    check("hold_eu_rs1", eu_rs1_o, 64'd101);

    // Round-robin dispatch 1,2,3 then wrap to 0
    eu_ready_i = 1'b1;
    #1;
    check("rr_first", 64'(eu_entry_idx_o), 64'd1);
    tick();
    check("rr_second", 64'(eu_entry_idx_o), 64'd2);
    check("rr_second_rs2", eu_rs2_o, 64'd202);
    tick();
    check("rr_third", 64'(eu_entry_idx_o), 64'd3);
    tick();
    check("rr_none_ready", 64'(eu_valid_o), 64'd0);
    bcast(6'd20, 64'h5A, 1'b0);
    tick();
    cdb_valid_i = 1'b0;
    #1;
    check("rr_wrap_valid", 64'(eu_valid_o), 64'd1);
    check("rr_wrap_idx",   64'(eu_entry_idx_o), 64'd0);
    check("rr_wrap_rs1",   eu_rs1_o, 64'h5A);
    tick(); idle(); #1;
    check("rr_all_issued", 64'(eu_valid_o), 64'd0);

    // Out-of-order completion: entry 2 first, with exception code 2
    complete(3'd2, 64'h222, 1'b1, 2'd2);
    tick(); idle(); #1;
    check("ooo_cdb_valid", 64'(cdb_valid_o), 64'd1);
    check("ooo_cdb_idx",   64'(cdb_idx_o), 64'd12);
    check("ooo_cdb_data",  cdb_data_o, 64'h222);
    check("ooo_cdb_exc",   64'(cdb_except_raised_o), 64'd1);
    check("ooo_cdb_code",  64'(cdb_except_o), 64'd2);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_cdb_valid", 64'(cdb_valid_o), 64'd1);
      check("stall_cdb_idx",   64'(cdb_idx_o), 64'd12);
      check("stall_cdb_data",  cdb_data_o, 64'h222);
    end

    // Writeback of 2 while full, an insert attempt, and completion of entry 0 all together
    cdb_ready_i = 1'b1;
    put(4'hF, 1'b1, 6'd0, 64'd1, 1'b1, 6'd0, 64'd1, 6'd40);
    complete(3'd0, 64'h200, 1'b0, 2'd0);
    #1;
    check("full_wb_arb_ready", 64'(arbiter_ready_o), 64'd0);
    tick(); idle(); #1;
    check("after_wb_arb_ready", 64'(arbiter_ready_o), 64'd1);
    check("after_wb_occ",       64'(occupancy_o), 64'd7);
    check("second_cdb_valid",   64'(cdb_valid_o), 64'd1);
    check("second_cdb_idx",     64'(cdb_idx_o), 64'd10);
    check("second_cdb_data",    cdb_data_o, 64'h200);
    check("second_cdb_exc",     64'(cdb_except_raised_o), 64'd0);
    flush_i = 1'b1;
    #1;
    check("flush_masks_cdb", 64'(cdb_valid_o), 64'd0);
    tick(); idle(); #1;
    check("flush7_occ", 64'(occupancy_o), 64'd0);
    check("flush7_arb", 64'(arbiter_ready_o), 64'd1);

    // Flush with 4 occupied and one ISSUED, then a late EU result
    for (int k = 0; k < 4; k++) begin
      put(4'h4, 1'b1, 6'd0, 64'(k), 1'b1, 6'd0, 64'd1, 6'(30 + k));
      tick();
    end
    idle(); #1;
    check("f4_occ", 64'(occupancy_o), 64'd4);
    check("f4_idx", 64'(eu_entry_idx_o), 64'd1);
    eu_ready_i = 1'b1;
    tick(); idle();
    flush_i = 1'b1;
    #1;
    check("f4_flush_masks_eu", 64'(eu_valid_o), 64'd0);
    tick(); idle(); #1;
    check("f4_occ_after", 64'(occupancy_o), 64'd0);
    complete(3'd1, 64'h999, 1'b0, 2'd0);
    tick(); idle(); #1;
    check("late_cdb_valid", 64'(cdb_valid_o), 64'd0);
    check("late_occ",       64'(occupancy_o), 64'd0);
    check("late_eu_valid",  64'(eu_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
